bias_buf: RTL

BIAS_BUF -- requirements
Module: bias_buf

---
 rtl/bias_buf.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/bias_buf.sv
// Bias vector buffer: assembles input beats into bias vectors, queues up to DEPTH of them,
// and loads one onto bias_out a fixed DLY cycles after each layer request is served.
module bias_buf #(
  parameter int BANDWIDTH = 512,
  parameter int BITWIDTH  = 32,
  parameter int CH        = 16,
  parameter int DEPTH     = 8,
  parameter int DLY       = 15
) (
  input  logic                       clk_calc,
  input  logic                       rst,
  input  logic                       bias_in_vld,
  output logic                       bias_in_rdy,
  input  logic [BANDWIDTH-1:0]       bias_in,
  input  logic                       bias_en,
  input  logic                       data_acc_layer_finish,
  input  logic                       bias_flush,
  output logic                       bias_load_done,
  output logic [BITWIDTH*CH-1:0]     bias_out,
  output logic [$clog2(DEPTH+1)-1:0] bias_level,
  output logic                       bias_err,
  output logic [1:0]                 dbg_state
);
  localparam int VW    = BITWIDTH * CH;
  localparam int BEATS = VW / BANDWIDTH;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEATS - 1);
  localparam logic [LW-1:0]  LVL_FULL  = LW'(DEPTH);
  localparam logic [AW-1:0]  PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [4:0]     CNT_END   = 5'(DLY);
  localparam logic [4:0]     CNT_FIRE  = (DLY == 0) ? 5'd0 : 5'(DLY - 1);

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DELAY = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           pend_q, pend_d;
  logic           err_q, err_d;
  logic [LW-1:0]  level_q, level_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic [VW-1:0]  asm_q, asm_d;
  logic [VW-1:0]  hold_q, hold_d;
  logic [VW-1:0]  out_q, out_d;
  logic           done_q, done_d;
  logic [VW-1:0]  mem_q [DEPTH];
  logic [VW-1:0]  rd_vec;
  logic           accept, wr_en, pop, fire;

  // Input handshake: a beat transfers on a rising edge where bias_in_vld && bias_in_rdy are both 1;
  // rdy depends only on registered level (plus rst/flush), never on vld or a same-cycle pop.
  always_comb begin
    bias_in_rdy = !rst && !bias_flush && (level_q < LVL_FULL);
    accept      = bias_in_vld && bias_in_rdy;
    asm_d       = asm_q;
    beat_d      = beat_q;
    wr_en       = 1'b0;
    if (accept) begin
      for (int k = 0; k < BEATS; k++) begin
        if (beat_q == BCW'(k)) asm_d[k*BANDWIDTH +: BANDWIDTH] = bias_in;
      end
      if (beat_q == BEAT_LAST) begin
        wr_en  = 1'b1;
        beat_d = '0;
      end else begin
        beat_d = beat_q + BCW'(1);
      end
    end
    if (bias_flush) beat_d = '0;
  end

  always_comb begin
    rd_vec   = mem_q[rd_ptr_q];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
    if (wr_en && !pop)      level_d = level_q + LW'(1);
    else if (!wr_en && pop) level_d = level_q - LW'(1);
    if (bias_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // DELAY spans DLY counting cycles plus one final cycle in which the new vector is visible
  // and a pending (or coincident) request is served as if the FSM were already idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    err_d   = err_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_FIRST: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = ST_DELAY;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (data_acc_layer_finish) begin
          if (level_q != '0) begin
            pop     = 1'b1;
            state_d = ST_DELAY;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (data_acc_layer_finish) begin
          if (pend_q) err_d = 1'b1;
          else        pend_d = 1'b1;
        end
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = ST_DELAY;
          cnt_d   = '0;
        end
      end
      ST_DELAY: begin
        if (cnt_q != CNT_END) begin
          cnt_d = cnt_q + 5'd1;
          if (data_acc_layer_finish) begin
            if (pend_q) err_d = 1'b1;
            else        pend_d = 1'b1;
          end
        end else if (pend_q || data_acc_layer_finish) begin
          pend_d = pend_q && data_acc_layer_finish;
          if (level_q != '0) begin
            pop     = 1'b1;
            state_d = ST_DELAY;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_FIRST;
    endcase
    if (bias_flush) begin
      state_d = ST_FIRST;
      cnt_d   = '0;
      pend_d  = 1'b0;
      pop     = 1'b0;
    end
    if (DLY == 0) fire = pop;
    else          fire = (state_q == ST_DELAY) && (cnt_q == CNT_FIRE) && !bias_flush;
  end

  always_comb begin
    hold_d = hold_q;
    out_d  = out_q;
    done_d = 1'b0;
    if (pop) hold_d = rd_vec;
    if (fire) begin
      out_d  = (DLY == 0) ? rd_vec : hold_q;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_calc) begin
    if (rst) begin
      state_q  <= ST_FIRST;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      beat_q   <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  // Storage needs no reset: level and pointers define which entries are meaningful.
  always_ff @(posedge clk_calc) begin
    asm_q  <= asm_d;
    hold_q <= hold_d;
    if (wr_en) mem_q[wr_ptr_q] <= asm_d;
  end

  assign bias_out       = bias_en ? out_q : '0;
  assign bias_load_done = done_q;
  assign bias_level     = level_q;
  assign bias_err       = err_q;
  assign dbg_state      = state_q;

endmodule
